// File: rtl/mmio_pkg.sv
// Shared constants, funct3 encoding and timebase helper for the MMIO responder.
package mmio_pkg;

  localparam logic [31:0] MMIO_DUTY   = 32'hFFFF_FFFC;
  localparam logic [31:0] MMIO_MILLIS = 32'hFFFF_FFF8;
  localparam logic [31:0] MMIO_MICROS = 32'hFFFF_FFF4;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  // Clock cycles per microsecond; the clock must be an exact multiple of 1 MHz.
  function automatic int unsigned prescale_of(input int unsigned clk_hz);
    return clk_hz / 1_000_000;
  endfunction

endpackage

// File: rtl/mmio_timebase.sv
// Free-running micros/millis counters derived from the system clock.
module mmio_timebase
  import mmio_pkg::*;
#(
  parameter int unsigned PRESCALE = 12
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] micros,
  output logic [31:0] millis
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    ms_q, ms_d;
  logic [31:0]   micros_q, micros_d;
  logic [31:0]   millis_q, millis_d;
  logic          us_tick;

  always_comb begin
    us_tick  = (presc_q == PW'(PRESCALE - 1));
    presc_d  = us_tick ? '0 : presc_q + 1'b1;
    micros_d = micros_q;
    millis_d = millis_q;
    ms_d     = ms_q;
    if (us_tick) begin
      micros_d = micros_q + 32'd1;
      if (ms_q == 10'd999) begin
        ms_d     = '0;
        millis_d = millis_q + 32'd1;
      end else begin
        ms_d = ms_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q  <= '0;
      ms_q     <= '0;
      micros_q <= '0;
      millis_q <= '0;
    end else begin
      presc_q  <= presc_d;
      ms_q     <= ms_d;
      micros_q <= micros_d;
      millis_q <= millis_d;
    end
  end

  assign micros = micros_q;
  assign millis = millis_q;

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder for the 0xFFFFFFF0 window: PWM duty register plus micros/millis counters.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 12_000_000,
  parameter bit          OUT_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        LED,
  output logic        RGB_B,
  output logic        RGB_G,
  output logic        RGB_R
);

  localparam int unsigned PRESCALE = prescale_of(CLK_FREQ_HZ);

  logic [31:0] micros, millis;

  mmio_timebase #(.PRESCALE(PRESCALE)) u_timebase (
    .clk    (clk),
    .reset  (reset),
    .micros (micros),
    .millis (millis)
  );

  logic [31:0] duty_q, duty_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [3:0]  pins_q, pins_d;

  logic        hit, legal, aligned, acc_err;
  logic [31:0] word_addr, rd_word, rd_shift, ld_data, wr_mask;
  logic [4:0]  shamt;

  always_comb begin
    word_addr = {req_addr[31:2], 2'b00};
    shamt     = {req_addr[1:0], 3'b000};
    hit       = (req_addr[31:4] == 28'hFFF_FFFF);
    legal     = 1'b1;
    aligned   = 1'b1;
    wr_mask   = '0;
    ld_data   = '0;
    rd_word   = '0;
    if (hit) begin
      case (word_addr)
        MMIO_DUTY:   rd_word = duty_q;
        MMIO_MILLIS: rd_word = millis;
        MMIO_MICROS: rd_word = micros;
        default:     rd_word = '0;
      endcase
    end
    rd_shift = rd_word >> shamt;

    // Unsigned widths leave wr_mask at zero, so bu/hu stores write nothing.
    case (req_funct3)
      F3_B: begin
        ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
        wr_mask = 32'h0000_00FF << shamt;
      end
      F3_BU: ld_data = {24'h0, rd_shift[7:0]};
      F3_H: begin
        aligned = ~req_addr[0];
        ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
        wr_mask = 32'h0000_FFFF << shamt;
      end
      F3_HU: begin
        aligned = ~req_addr[0];
        ld_data = {16'h0, rd_shift[15:0]};
      end
      F3_W: begin
        aligned = (req_addr[1:0] == 2'b00);
        ld_data = rd_shift;
        wr_mask = '1;
      end
      default: legal = 1'b0;
    endcase
    acc_err = ~legal | ~aligned;

    duty_d = duty_q;
    if (req_valid && req_write && !acc_err && hit && word_addr == MMIO_DUTY)
      duty_d = (duty_q & ~wr_mask) | ((req_wdata << shamt) & wr_mask);

    rsp_valid_d = req_valid;
    rsp_err_d   = req_valid & acc_err;
    rsp_rdata_d = (req_valid && !req_write && !acc_err) ? ld_data : '0;

    pwm_cnt_d = pwm_cnt_q + 8'd1;
    pins_d    = '0;
    for (int unsigned i = 0; i < 4; i++)
      pins_d[i] = (pwm_cnt_q < duty_q[8*i +: 8]) ^ OUT_ACTIVE_LOW;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      duty_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      pwm_cnt_q   <= '0;
      pins_q      <= {4{OUT_ACTIVE_LOW}};
    end else begin
      duty_q      <= duty_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      pwm_cnt_q   <= pwm_cnt_d;
      pins_q      <= pins_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign LED       = pins_q[0];
  assign RGB_B     = pins_q[1];
  assign RGB_G     = pins_q[2];
  assign RGB_R     = pins_q[3];

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
Memory-mapped I/O responder serving CPU load/store requests in the 0xFFFFFFF0–0xFFFFFFFF window.
- Holds four 8-bit PWM duty registers that drive LED, RGB_R, RGB_G and RGB_B.
- Exposes free-running micros and millis counters.
- Sits beside instruction/data memory in top; the datapath routes MMIO-addressed accesses here.
- Single-cycle registered response.

Parameters:
CLK_FREQ_HZ, 12_000_000, input clock frequency; micros prescale = CLK_FREQ_HZ/1_000_000 (must divide exactly).
OUT_ACTIVE_LOW, 1, when 1 the LED/RGB pins are inverted (on = 0).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
req_valid  input  1  request strobe, one request per asserted cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte/half in low bits)
req_funct3  input  3  RISC-V width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
rsp_valid  output  1  response strobe, one cycle after req_valid
rsp_rdata  output  32  load result, extended per funct3; 0 for stores
rsp_err  output  1  misaligned access or illegal funct3; qualifies rsp_valid
LED  output  1  PWM output, duty byte0
RGB_B  output  1  PWM output, duty byte1
RGB_G  output  1  PWM output, duty byte2
RGB_R  output  1  PWM output, duty byte3

Behaviour:
- Reset, sampled when reset==0 at a clk edge:
  - duty, micros, millis, prescaler and pwm_cnt all cleared to 0.
  - rsp_valid, rsp_err and rsp_rdata = 0.
  - Pins at the off level (1 if OUT_ACTIVE_LOW).
  - A request in flight when reset asserts is dropped; no response is issued.
- Address map (hit when req_addr[31:4] == 28'hFFFFFFF):
  - 0xFFFFFFFC: DUTY, R/W, bytes {R,G,B,LED} from [31:24] down to [7:0].
  - 0xFFFFFFF8: MILLIS, read-only.
  - 0xFFFFFFF4: MICROS, read-only.
  - 0xFFFFFFF0: reserved, reads 0.
  - Stores to read-only, reserved or non-hit addresses are ignored. Loads from them return 0. rsp_err stays 0 for these.
- Alignment:
  - Half access requires addr[0]=0; word access requires addr[1:0]=00.
  - funct3 values 011, 110 and 111 are illegal.
  - A misaligned or illegal access produces rsp_err=1 and rsp_rdata=0, and has no side effect.
- Store to DUTY:
  - The lane from addr[1:0] takes req_wdata low byte (sb), low half (sh) or full word (sw).
  - Other lanes are unchanged.
  - Takes effect at the request edge.
- Load:
  - Select the word, shift right by 8*addr[1:0], then mask and extend.
  - b and h sign-extend; bu and hu zero-extend.
- Latency:
  - rsp_valid is asserted exactly 1 cycle after each req_valid, including stores, errors and misses.
  - Back-to-back requests are accepted every cycle.
  - No backpressure.
- Timing of counter and duty reads:
  - A counter read returns the value held at the request edge; a tick at the same edge is not visible.
  - A load of DUTY in the cycle after a store returns the new value.
- Timebase:
  - Prescaler counts 0..P-1, where P = CLK_FREQ_HZ/1e6.
  - At P-1 the prescaler wraps and micros increments; this is the usec tick.
  - A sub-counter of 0..999 on usec ticks increments millis on wrap.
  - micros and millis wrap 0xFFFFFFFF→0.
- PWM:
  - Shared 8-bit pwm_cnt free-runs and wraps 255→0.
  - Channel is on when pwm_cnt < duty. Duty 0 gives always off; duty 255 gives on 255 of every 256 cycles.
  - The output pin is registered: one cycle later than the compare.

Decomposition:
- Package mmio_pkg:
  - Address constants MMIO_DUTY, MMIO_MILLIS, MMIO_MICROS.
  - funct3 enum F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - Function computing the prescale value.
- Sub-module mmio_timebase (clk, reset, micros, millis): prescaler, micros, ms sub-counter, millis.
- PWM compare stays inline.

Test Plan:
- Hold reset=0 for 3 cycles, release → rsp_valid=0. All pins=1 with OUT_ACTIVE_LOW=1, and stay 1 for 256 cycles.
- sw 0x80FF4000 to 0xFFFFFFFC, then lw 0xFFFFFFFC → rsp_valid 1 cycle after, rsp_rdata=0x80FF4000. Over 256 cycles: LED on 0, RGB_B on 64, RGB_G on 255, RGB_R on 128 cycles.
- sb 0xAA at 0xFFFFFFFE → lw returns 0x80AA4000; lb at 0xFFFFFFFE returns 0xFFFFFFAA; lbu returns 0x000000AA; lh at 0xFFFFFFFE returns 0xFFFF80AA.
- Error and miss cases:
  - sh at 0xFFFFFFFD → rsp_err=1, DUTY unchanged.
  - lw at 0xFFFFFFFA → rsp_err=1, rdata=0.
  - funct3=011 → rsp_err=1.
  - sw to 0xFFFFFFF8 → no error, millis unaffected.
- Timebase check after reset:
  - Run 12*1000 + 5 cycles, read MICROS → 1000.
  - Read MILLIS → 1.
  - Force micros to 0xFFFFFFFF, run 12 cycles → reads 0.
- Reset mid-operation: assert reset in the cycle a lw is issued → no rsp_valid next cycle; DUTY reads 0 after release.
